// File: rtl/mux_rr_scheduler_pkg.sv
// Shared definitions for the round-robin select scheduler: widths, state codes,
// park value and small slicing helpers.
package mux_rr_scheduler_pkg;

    localparam int N_REQ = 4;
    localparam int SEL_W = 2;

    localparam logic [SEL_W-1:0] PARK_SEL_DEF = '0;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    function automatic logic [N_REQ-1:0] sel_onehot(input logic [SEL_W-1:0] idx);
        logic [N_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    function automatic logic [SEL_W-1:0] cfg_slice(input logic [SEL_W*N_REQ-1:0] cfg,
                                                   input logic [SEL_W-1:0]       idx);
        return cfg[idx*SEL_W +: SEL_W];
    endfunction

endpackage

// File: rtl/mux_rr_scheduler_if.sv
// Request/grant bundle between the requesting logic and the select scheduler.
interface mux_rr_scheduler_if;
    import mux_rr_scheduler_pkg::*;

    // req is a level request held until the requester is done; grant is the
    // registered one-hot answer and may be withdrawn while req is still high.
    logic [N_REQ-1:0]       req;
    logic [SEL_W*N_REQ-1:0] cfg_sel2;
    logic [N_REQ-1:0]       grant;
    logic [SEL_W-1:0]       sel1;
    logic [SEL_W-1:0]       sel2;
    logic                   busy;

    modport master (output req, cfg_sel2, input grant, sel1, sel2, busy);
    modport slave  (input req, cfg_sel2, output grant, sel1, sel2, busy);

endinterface

// File: rtl/mux_rr_scheduler_rr_pick4.sv
// Combinational round-robin picker: first set request after i_last, wrapping mod 4.
module rr_pick4 (
    input  logic [3:0] i_req,
    input  logic [1:0] i_last,
    output logic [1:0] o_winner,
    output logic       o_any
);

    logic [1:0] w_idx;
    logic       w_found;

    always_comb begin
        o_winner = i_last;
        w_found  = 1'b0;
        w_idx    = i_last;
        for (int k = 1; k <= 4; k++) begin
            w_idx = i_last + 2'(k);
            if (!w_found && i_req[w_idx]) begin
                o_winner = w_idx;
                w_found  = 1'b1;
            end
        end
        o_any = |i_req;
    end

endmodule

// File: rtl/mux_rr_scheduler.sv
// Round-robin owner of SEL1/SEL2 for the shared 4:1 datapath; grants last up to
// HOLD_CYC cycles and are always followed by one parked cycle.
module mux_rr_scheduler
    import mux_rr_scheduler_pkg::*;
#(
    parameter int               HOLD_CYC = 4,
    parameter logic [SEL_W-1:0] PARK_SEL = PARK_SEL_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    mux_rr_scheduler_if.slave   bus,
    output logic [1:0]          o_dbg_state
);

    localparam int               CNT_W    = $clog2(HOLD_CYC) + 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYC - 1);

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_last;
    logic [N_REQ-1:0] r_grant;
    logic [SEL_W-1:0] r_sel1;
    logic [SEL_W-1:0] r_sel2;
    logic             r_busy;

    logic [1:0] w_winner;
    logic       w_any;
    logic       w_arb;
    logic       w_release;

    rr_pick4 u_pick (
        .i_req    (bus.req),
        .i_last   (r_last),
        .o_winner (w_winner),
        .o_any    (w_any)
    );

    // Only request levels at the arbitration edge matter; nothing is queued.
    assign w_arb     = (r_state == ST_IDLE || r_state == ST_GAP) && w_any;
    assign w_release = (r_state == ST_GRANT) && (!bus.req[r_sel1] || r_cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_last  <= 2'd3;
            r_grant <= '0;
            r_sel1  <= PARK_SEL;
            r_sel2  <= PARK_SEL;
            r_busy  <= 1'b0;
        end else if (w_arb) begin
            r_state <= ST_GRANT;
            r_grant <= sel_onehot(w_winner);
            r_sel1  <= w_winner;
            r_sel2  <= cfg_slice(bus.cfg_sel2, w_winner);
            r_cnt   <= CNT_LOAD;
            r_busy  <= 1'b1;
        end else if (w_release) begin
            r_state <= ST_GAP;
            r_last  <= r_sel1;
            r_grant <= '0;
            r_sel1  <= PARK_SEL;
            r_sel2  <= PARK_SEL;
            r_busy  <= 1'b0;
        end else if (r_state == ST_GRANT) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end else begin
            // GAP with no request, or an unused encoding, falls back to IDLE.
            r_state <= ST_IDLE;
        end
    end

    assign bus.grant   = r_grant;
    assign bus.sel1    = r_sel1;
    assign bus.sel2    = r_sel2;
    assign bus.busy    = r_busy;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mux_rr_scheduler.sv
// Bench for mux_rr_scheduler: HOLD_CYC=4 and HOLD_CYC=1 instances on shared inputs.
module tb_mux_rr_scheduler;
    import mux_rr_scheduler_pkg::*;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] tb_req = '0;
    logic [7:0] tb_cfg = '0;
    logic [1:0] dbg_a;
    logic [1:0] dbg_b;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mux_rr_scheduler_if if_a ();
    mux_rr_scheduler_if if_b ();

    assign if_a.req      = tb_req;
    assign if_a.cfg_sel2 = tb_cfg;
    assign if_b.req      = tb_req;
    assign if_b.cfg_sel2 = tb_cfg;

    mux_rr_scheduler #(.HOLD_CYC(4)) dut_a (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (if_a),
        .o_dbg_state (dbg_a)
    );

    mux_rr_scheduler #(.HOLD_CYC(1)) dut_b (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (if_b),
        .o_dbg_state (dbg_b)
    );

    // Reference model: who owns the path, for how many cycles, last owner.
    int         m_owner [2];
    int         m_age   [2];
    int         m_last  [2];
    bit         m_gap   [2];
    logic [1:0] m_sel2  [2];

    function automatic int hold_of(input int d);
        return (d == 0) ? 4 : 1;
    endfunction

    function automatic int rr_pick(input int last, input logic [3:0] r);
        for (int k = 1; k <= 4; k++) begin
            if (r[(last + k) % 4]) return (last + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_reset;
        for (int d = 0; d < 2; d++) begin
            m_owner[d] = -1;
            m_age[d]   = 0;
            m_last[d]  = 3;
            m_gap[d]   = 1'b0;
            m_sel2[d]  = 2'd0;
        end
    endtask

    task automatic model_edge;
        int w;
        for (int d = 0; d < 2; d++) begin
            if (m_owner[d] >= 0) begin
                if (!tb_req[m_owner[d]] || m_age[d] == hold_of(d)) begin
                    m_last[d]  = m_owner[d];
                    m_owner[d] = -1;
                    m_gap[d]   = 1'b1;
                end else begin
                    m_age[d]++;
                end
            end else begin
                w = rr_pick(m_last[d], tb_req);
                m_gap[d] = 1'b0;
                if (w >= 0) begin
                    m_owner[d] = w;
                    m_age[d]   = 1;
                    m_sel2[d]  = tb_cfg[2*w +: 2];
                end
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model;
        logic [3:0] eg;
        logic [1:0] es1, es2, est;
        logic       eb;
        for (int d = 0; d < 2; d++) begin
            eg  = (m_owner[d] >= 0) ? (4'b0001 << m_owner[d]) : 4'b0000;
            es1 = (m_owner[d] >= 0) ? 2'(m_owner[d]) : 2'd0;
            es2 = (m_owner[d] >= 0) ? m_sel2[d] : 2'd0;
            eb  = (m_owner[d] >= 0);
            est = (m_owner[d] >= 0) ? 2'd1 : (m_gap[d] ? 2'd2 : 2'd0);
            check($sformatf("model d%0d grant", d), (d == 0) ? if_a.grant : if_b.grant, eg);
            check($sformatf("model d%0d sel1", d),  (d == 0) ? if_a.sel1  : if_b.sel1,  es1);
            check($sformatf("model d%0d sel2", d),  (d == 0) ? if_a.sel2  : if_b.sel2,  es2);
            check($sformatf("model d%0d busy", d),  (d == 0) ? if_a.busy  : if_b.busy,  eb);
            check($sformatf("model d%0d state", d), (d == 0) ? dbg_a      : dbg_b,      est);
        end
    endtask

    task automatic step;
        @(posedge clk);
        if (rst_n) model_edge();
        #1;
        check_model();
    endtask

    // Asserts reset between edges and checks the outputs clear without a clock.
    task automatic do_reset;
        #2;
        rst_n = 1'b0;
        #1;
        check("rst grant a", if_a.grant, 4'b0000);
        check("rst sel1 a",  if_a.sel1,  2'd0);
        check("rst sel2 a",  if_a.sel2,  2'd0);
        check("rst busy a",  if_a.busy,  1'b0);
        check("rst grant b", if_b.grant, 4'b0000);
        check("rst busy b",  if_b.busy,  1'b0);
        model_reset();
        tb_req = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [3:0] req;
        logic [7:0] cfg;
        logic [3:0] grant;
        logic [1:0] sel1;
        logic [1:0] sel2;
        logic       busy;
    } vec_t;

    vec_t tbl [10];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 10; i++) begin
            if (i == 4 || i == 9)
                tbl[i] = '{4'b0100, 8'hE4, 4'b0000, 2'd0, 2'd0, 1'b0};
            else
                tbl[i] = '{4'b0100, 8'hE4, 4'b0100, 2'd2, 2'b10, 1'b1};
        end

        model_reset();
        do_reset();

        // Single requester 2 held: 4-cycle grants split by one gap.
        for (int i = 0; i < 10; i++) begin
            tb_req = tbl[i].req;
            tb_cfg = tbl[i].cfg;
            step();
            check($sformatf("tbl[%0d] grant", i), if_a.grant, tbl[i].grant);
            check($sformatf("tbl[%0d] sel1", i),  if_a.sel1,  tbl[i].sel1);
            check($sformatf("tbl[%0d] sel2", i),  if_a.sel2,  tbl[i].sel2);
            check($sformatf("tbl[%0d] busy", i),  if_a.busy,  tbl[i].busy);
        end

        // Reset lands in the middle of a grant.
        step();
        check("pre-reset grant", if_a.grant, 4'b0100);
        do_reset();

        // All requesting: fairness order for both hold lengths.
        tb_req = 4'hF;
        tb_cfg = 8'h1B;
        for (int t = 0; t < 25; t++) begin
            step();
            check($sformatf("rr4 t%0d", t), if_a.grant,
                  ((t % 5) == 4) ? 4'b0000 : (4'b0001 << ((t / 5) % 4)));
            check($sformatf("rr1 t%0d", t), if_b.grant,
                  (t[0]) ? 4'b0000 : (4'b0001 << ((t / 2) % 4)));
        end

        // Early release by request drop, then rotation skips the old owner.
        do_reset();
        tb_req = 4'b0010;
        step();
        check("drop grant1", if_a.grant, 4'b0010);
        step();
        check("drop grant1 c2", if_a.grant, 4'b0010);
        tb_req = 4'b0001;
        step();
        check("drop release", if_a.grant, 4'b0000);
        tb_req = 4'b0011;
        step();
        check("drop next winner", if_a.grant, 4'b0001);
        check("drop next sel1", if_a.sel1, 2'd0);

        // cfg_sel2 change mid-grant is ignored until the next grant.
        do_reset();
        tb_cfg = 8'h00;
        tb_req = 4'b1000;
        for (int t = 0; t < 6; t++) begin
            if (t == 1) tb_cfg = 8'hFF;
            step();
            check($sformatf("cfg t%0d sel2", t), if_a.sel2,
                  (t < 4) ? 2'd0 : ((t == 4) ? 2'd0 : 2'b11));
            check($sformatf("cfg t%0d grant", t), if_a.grant,
                  (t == 4) ? 4'b0000 : 4'b1000);
        end

        // Random traffic against the model, with one reset in the middle.
        do_reset();
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 9) < 3) tb_req = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 9) < 2) tb_cfg = 8'($urandom_range(0, 255));
            if (c == 200) do_reset();
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
